// File: rtl/vec_store_memory.sv
// Vector store unit: commits one LANES-wide store as saturated pixels, one lane
// per cycle, into a simple dual-port image RAM with a registered readback port.
//
// state   | meaning
// S_IDLE  | ready for a store request
// S_WRITE | committing lane idx this cycle
// S_DONE  | store fully committed, done pulse
module vec_store_memory #(
  parameter int IMAGE_WIDTH  = 96,
  parameter int IMAGE_HEIGHT = 96,
  parameter int PIX_SIZE     = 8,
  parameter int LANES        = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                st_valid,
  output logic                st_ready,
  input  logic [15:0]         st_addr,
  input  logic [15:0][15:0]   st_data,
  input  logic [LANES-1:0]    st_mask,
  output logic                busy,
  output logic                done,
  output logic                oob_err,
  input  logic [15:0]         rd_addr,
  output logic [PIX_SIZE-1:0] rd_data
);

  localparam int DEPTH  = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int MEM_AW = $clog2(DEPTH);
  localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [16:0]      DEPTH_W  = 17'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
  localparam logic [15:0]      PIX_MAX  = 16'((1 << PIX_SIZE) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                  state;
  state_t                  state_n;
  logic [IDX_W-1:0]        idx;
  logic [15:0]             addr_q;
  logic [LANES-1:0][15:0]  lane_q;
  logic [LANES-1:0]        mask_q;

  logic [15:0]             cur_lane;
  logic [16:0]             wr_addr;
  logic                    in_range;
  logic                    lane_active;
  logic                    wr_en;
  logic [PIX_SIZE-1:0]     wr_pix;

  logic [PIX_SIZE-1:0]     mem [DEPTH];

  // Lanes are signed; negative clamps to zero, large values clamp to full scale.
  function automatic logic [PIX_SIZE-1:0] pix_sat(input logic [15:0] v);
    if (v[15])
      return '0;
    else if (v > PIX_MAX)
      return '1;
    else
      return v[PIX_SIZE-1:0];
  endfunction

  generate
    if (LANES < 16) begin : g_unused
      logic unused_hi_lanes;
      assign unused_hi_lanes = ^st_data[15:LANES];
    end
  endgenerate

  assign cur_lane    = lane_q[idx];
  assign lane_active = mask_q[idx];
  // 17-bit sum so an address near 16'hFFFF runs out of range instead of wrapping.
  assign wr_addr     = 17'(addr_q) + 17'(idx);
  assign in_range    = (wr_addr < DEPTH_W);
  assign wr_pix      = pix_sat(cur_lane);
  assign wr_en       = RST_N && (state == S_WRITE) && lane_active && in_range;

  always_comb begin
    state_n  = state;
    st_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        st_ready = 1'b1;
        if (st_valid) state_n = S_WRITE;
      end
      S_WRITE: begin
        busy = 1'b1;
        if (idx == LAST_IDX) state_n = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      idx     <= '0;
      oob_err <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_WRITE: begin
          idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
          if (lane_active && !in_range) oob_err <= 1'b1;
        end
        default: idx <= '0;
      endcase
    end
  end

  // Request fields are captured at the handshake so upstream may move on.
  always_ff @(posedge CLK) begin
    if (state == S_IDLE && st_valid) begin
      addr_q <= st_addr;
      mask_q <= st_mask;
      for (int i = 0; i < LANES; i++) lane_q[i] <= st_data[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr[MEM_AW-1:0]] <= wr_pix;
  end

  // Read-before-write: a same-edge write to rd_addr shows up on the next read.
  always_ff @(posedge CLK) begin
    if (!RST_N)
      rd_data <= '0;
    else if ({1'b0, rd_addr} < DEPTH_W)
      rd_data <= mem[rd_addr[MEM_AW-1:0]];
    else
      rd_data <= '0;
  end

endmodule

// File: tb/tb_vec_store_memory.sv
// Directed bench for vec_store_memory: an edge-level reference model is compared
// with the DUT every cycle, plus literal expectations for each scenario.
module tb_vec_store_memory;

  localparam int DEPTH = 96 * 96;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              st_valid = 1'b0;
  logic              st_ready;
  logic [15:0]       st_addr = '0;
  logic [15:0][15:0] st_data = '0;
  logic [7:0]        st_mask = '0;
  logic              busy;
  logic              done;
  logic              oob_err;
  logic [15:0]       rd_addr = '0;
  logic [7:0]        rd_data;

  always #5 CLK = ~CLK;

  vec_store_memory dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_mask  (st_mask),
    .busy     (busy),
    .done     (done),
    .oob_err  (oob_err),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] pix(input logic [15:0] v);
    int s;
    s = int'($signed(v));
    if (s < 0) return 8'h00;
    if (s > 255) return 8'hFF;
    return s[7:0];
  endfunction

  // Reference model. m_since counts edges since the accepting edge:
  // edges +1..+8 commit lanes 0..7, the cycle after edge +8 shows done,
  // and the block is idle again after edge +9.
  int              m_since = -1;
  int              m_a;
  logic [15:0]     m_addr;
  logic [7:0][15:0] m_lanes;
  logic [7:0]      m_mask;
  bit              m_oob = 1'b0;
  logic [7:0]      m_rd = '0;
  bit              m_rd_known = 1'b0;
  logic [7:0]      m_mem [DEPTH];
  bit              m_known [DEPTH];

  always @(posedge CLK) begin
    if (!RST_N) begin
      m_since    = -1;
      m_oob      = 1'b0;
      m_rd       = 8'h00;
      m_rd_known = 1'b1;
    end else begin
      if (int'(rd_addr) < DEPTH) begin
        m_rd       = m_mem[rd_addr];
        m_rd_known = m_known[rd_addr];
      end else begin
        m_rd       = 8'h00;
        m_rd_known = 1'b1;
      end
      if (m_since < 0) begin
        if (st_valid) begin
          m_addr = st_addr;
          m_mask = st_mask;
          for (int i = 0; i < 8; i++) m_lanes[i] = st_data[i];
          m_since = 0;
        end
      end else if (m_since < 8) begin
        m_a = int'(m_addr) + m_since;
        if (m_mask[m_since]) begin
          if (m_a >= DEPTH) m_oob = 1'b1;
          else begin
            m_mem[m_a]   = pix(m_lanes[m_since]);
            m_known[m_a] = 1'b1;
          end
        end
        m_since++;
      end else begin
        m_since = -1;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("model_ready", 32'(st_ready), 32'(m_since < 0));
      check("model_busy", 32'(busy), 32'(m_since >= 0));
      check("model_done", 32'(done), 32'(m_since == 8));
      check("model_oob", 32'(oob_err), 32'(m_oob));
      if (m_rd_known) check("model_rd", 32'(rd_data), 32'(m_rd));
    end
  end

  logic [7:0][15:0] lv;

  task automatic drive(input logic [15:0] a, input logic [7:0] m);
    st_addr = a;
    st_mask = m;
    for (int i = 0; i < 8; i++) st_data[i] = lv[i];
    for (int i = 8; i < 16; i++) st_data[i] = 16'($urandom);
  endtask

  task automatic scramble();
    st_addr = 16'($urandom);
    st_mask = 8'($urandom);
    for (int i = 0; i < 16; i++) st_data[i] = 16'($urandom);
  endtask

  // Returns at the negedge right after the accepting edge; acc = that edge number.
  task automatic do_store(input logic [15:0] a, input logic [7:0] m, output int acc);
    int n;
    n = 0;
    @(negedge CLK);
    drive(a, m);
    st_valid = 1'b1;
    while (!st_ready && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (!st_ready) check("accept_timeout", 32'd0, 32'd1);
    acc = cyc + 1;
    @(negedge CLK);
    st_valid = 1'b0;
    scramble();
  endtask

  // Returns at the negedge where done is seen; de = edge that samples done.
  task automatic wait_done(output int de);
    int n;
    n  = 0;
    de = -1;
    while (de < 0 && n < 30) begin
      @(negedge CLK);
      if (done) de = cyc + 1;
      n++;
    end
    if (de < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic store(input logic [15:0] a, input logic [7:0] m);
    int acc;
    int de;
    do_store(a, m, acc);
    wait_done(de);
  endtask

  task automatic fill(input logic [15:0] a, input logic [15:0] v);
    for (int i = 0; i < 8; i++) lv[i] = v;
    store(a, 8'hFF);
  endtask

  task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
    @(negedge CLK);
    rd_addr = a;
    @(negedge CLK);
    check(name, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int acc2;
    int de;
    int n;
    logic [7:0] e [8];

    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_en = 1'b1;
    check("rst_ready", 32'(st_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_oob", 32'(oob_err), 32'd0);
    check("rst_rd", 32'(rd_data), 32'd0);
    RST_N = 1'b1;

    // 1: basic store, timing
    for (int i = 0; i < 8; i++) lv[i] = 16'(10 + i);
    do_store(16'd0, 8'hFF, acc);
    wait_done(de);
    check("t1_done_edge", 32'(de - acc), 32'd9);
    check("t1_ready_at_done", 32'(st_ready), 32'd0);
    @(negedge CLK);
    check("t1_ready_after", 32'(st_ready), 32'd1);
    check("t1_done_pulse", 32'(done), 32'd0);
    for (int i = 0; i < 8; i++) rd_chk($sformatf("t1_rd%0d", i), 16'(i), 8'(8'h0A + i));

    // 2: saturation
    lv[0] = 16'hFFFB; lv[1] = 16'd300; lv[2] = 16'd255; lv[3] = 16'h7FFF;
    lv[4] = 16'h8000; lv[5] = 16'd128; lv[6] = 16'd1;   lv[7] = 16'd0;
    e[0] = 8'h00; e[1] = 8'hFF; e[2] = 8'hFF; e[3] = 8'hFF;
    e[4] = 8'h00; e[5] = 8'h80; e[6] = 8'h01; e[7] = 8'h00;
    store(16'd16, 8'hFF);
    for (int i = 0; i < 8; i++) rd_chk($sformatf("t2_rd%0d", i), 16'(16 + i), e[i]);

    // masked out-of-range lanes never flag
    fill(16'd9208, 16'h0055);
    for (int i = 0; i < 8; i++) lv[i] = 16'(16'h61 + i);
    store(16'd9212, 8'h0F);
    check("oob_masked", 32'(oob_err), 32'd0);
    rd_chk("oobm_rd9215", 16'd9215, 8'h64);

    // 3: store straddling the end of memory
    for (int i = 0; i < 8; i++) lv[i] = 16'(16'h21 + i);
    store(16'd9212, 8'hFF);
    check("t3_oob_set", 32'(oob_err), 32'd1);
    rd_chk("t3_rd9211", 16'd9211, 8'h55);
    rd_chk("t3_rd9212", 16'd9212, 8'h21);
    rd_chk("t3_rd9215", 16'd9215, 8'h24);
    rd_chk("t3_rd_oob", 16'd9216, 8'h00);
    rd_chk("t3_rd_ffff", 16'hFFFF, 8'h00);

    // no 16-bit wrap
    for (int i = 0; i < 8; i++) lv[i] = 16'(16'h71 + i);
    store(16'hFFFC, 8'hFF);
    rd_chk("wrap_rd0", 16'd0, 8'h0A);
    rd_chk("wrap_rd3", 16'd3, 8'h0D);
    check("oob_sticky", 32'(oob_err), 32'd1);

    // 4: partial mask over preloaded AA
    fill(16'd32, 16'h00AA);
    for (int i = 0; i < 8; i++) lv[i] = 16'(1 + i);
    store(16'd32, 8'b1010_0101);
    e[0] = 8'h01; e[1] = 8'hAA; e[2] = 8'h03; e[3] = 8'hAA;
    e[4] = 8'hAA; e[5] = 8'h06; e[6] = 8'hAA; e[7] = 8'h08;
    for (int i = 0; i < 8; i++) rd_chk($sformatf("t4_rd%0d", i), 16'(32 + i), e[i]);

    // 5: reset sampled at the fourth edge after accept
    fill(16'd48, 16'h0077);
    for (int i = 0; i < 8; i++) lv[i] = 16'(16'h31 + i);
    do_store(16'd48, 8'hFF, acc);
    while (cyc < acc + 3) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    check("t5_ready", 32'(st_ready), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_oob_cleared", 32'(oob_err), 32'd0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (done) n++;
    end
    check("t5_no_done", 32'(n), 32'd0);
    for (int i = 0; i < 3; i++) rd_chk($sformatf("t5_rd%0d", i), 16'(48 + i), 8'(8'h31 + i));
    for (int i = 3; i < 8; i++) rd_chk($sformatf("t5_rd%0d", i), 16'(48 + i), 8'h77);

    // 6: back-to-back with valid held, read during the write edge
    fill(16'd64, 16'h0011);
    for (int i = 0; i < 8; i++) lv[i] = 16'(16'h40 + i);
    @(negedge CLK);
    drive(16'd64, 8'hFF);
    st_valid = 1'b1;
    rd_addr  = 16'd64;
    n = 0;
    while (!st_ready && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (!st_ready) check("t6_accept_timeout", 32'd0, 32'd1);
    acc = cyc + 1;
    @(negedge CLK);
    for (int i = 0; i < 8; i++) lv[i] = 16'(16'h50 + i);
    drive(16'd80, 8'hFF);
    @(negedge CLK);
    check("t6_rd_old", 32'(rd_data), 32'h11);
    @(negedge CLK);
    check("t6_rd_new", 32'(rd_data), 32'h40);
    n = 0;
    while (!st_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    acc2 = cyc + 1;
    check("t6_b2b_accept", 32'(acc2 - acc), 32'd10);
    @(negedge CLK);
    st_valid = 1'b0;
    scramble();
    wait_done(de);
    check("t6_b2_done_edge", 32'(de - acc2), 32'd9);
    rd_chk("t6_rd64", 16'd64, 8'h40);
    rd_chk("t6_rd71", 16'd71, 8'h47);
    rd_chk("t6_rd80", 16'd80, 8'h50);
    rd_chk("t6_rd87", 16'd87, 8'h57);

    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
